// File: rtl/sprite_dma_pkg.sv
// Shared types and address constants for the sprite page-copy DMA.
// Decode logic elsewhere reuses the trigger and sprite-base addresses.
package sprite_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } dma_state_t;

    localparam logic [15:0] SPRITE_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] SPRITE_DST_BASE  = 16'h4800;

endpackage

// File: rtl/sprite_dma.sv
// Owns the CPU-side memory port: passes CPU cycles through, or halts the CPU
// and copies one page to the sprite attribute region at 2 clocks per byte.
module sprite_dma
    import sprite_dma_pkg::*;
#(
    parameter int                     P_addr_bits = 16,
    parameter int                     P_data_bits = 8,
    parameter logic [P_addr_bits-1:0] P_trig_addr = SPRITE_TRIG_ADDR,
    parameter logic [P_addr_bits-1:0] P_dst_base  = SPRITE_DST_BASE,
    parameter int                     P_len       = 256
) (
    input  logic                   I_clock,
    input  logic                   I_reset,
    input  logic [P_addr_bits-1:0] I_cpu_addr,
    input  logic [P_data_bits-1:0] I_cpu_wr_data,
    input  logic                   I_cpu_rdwr,
    input  logic                   I_cpu_phy2,
    output logic [P_data_bits-1:0] O_cpu_rd_data,
    output logic                   O_cpu_ready,
    output logic [P_addr_bits-1:0] O_mem_addr,
    output logic [P_data_bits-1:0] O_mem_wr_data,
    output logic                   O_mem_wren,
    input  logic [P_data_bits-1:0] I_mem_rd_data,
    output logic                   O_dma_busy
);

    localparam int         SRC_W = P_data_bits + 8;
    localparam logic [8:0] LAST  = 9'(P_len - 1);

    dma_state_t             state, state_nxt;
    logic [P_data_bits-1:0] page, page_nxt;
    logic [P_data_bits-1:0] rd_hold, rd_hold_nxt;
    logic [8:0]             count, count_nxt;
    logic [SRC_W-1:0]       src_addr;
    logic [P_addr_bits-1:0] dst_addr;
    logic                   trig;

    assign src_addr = {page, count[7:0]};
    assign dst_addr = P_dst_base + P_addr_bits'(count);
    assign trig     = (state == ST_IDLE) && I_cpu_phy2 && !I_cpu_rdwr
                      && (I_cpu_addr == P_trig_addr);

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            state   <= ST_IDLE;
            page    <= '0;
            count   <= '0;
            rd_hold <= '0;
        end else begin
            state   <= state_nxt;
            page    <= page_nxt;
            count   <= count_nxt;
            rd_hold <= rd_hold_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        page_nxt      = page;
        count_nxt     = count;
        rd_hold_nxt   = rd_hold;
        O_mem_addr    = I_cpu_addr;
        O_mem_wr_data = I_cpu_wr_data;
        O_mem_wren    = I_cpu_phy2 && !I_cpu_rdwr;
        O_cpu_rd_data = I_mem_rd_data;
        O_cpu_ready   = 1'b0;
        O_dma_busy    = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                O_cpu_ready = 1'b1;
                if (trig) begin
                    O_mem_wren = 1'b0;
                    page_nxt   = I_cpu_wr_data;
                    count_nxt  = '0;
                    state_nxt  = ST_HALT;
                end
            end
            ST_HALT: begin
                // Only start once the CPU is parked on a read; writes still land.
                if (I_cpu_phy2 && I_cpu_rdwr) begin
                    rd_hold_nxt = I_mem_rd_data;
                    state_nxt   = ST_READ;
                end
            end
            ST_READ: begin
                O_mem_addr    = P_addr_bits'(src_addr);
                O_mem_wren    = 1'b0;
                O_cpu_rd_data = rd_hold;
                state_nxt     = ST_WRITE;
            end
            ST_WRITE: begin
                O_mem_addr    = dst_addr;
                O_mem_wr_data = I_mem_rd_data;
                O_mem_wren    = 1'b1;
                O_cpu_rd_data = rd_hold;
                if (count == LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    count_nxt = count + 9'd1;
                    state_nxt = ST_READ;
                end
            end
            ST_DONE: begin
                O_mem_addr    = dst_addr;
                O_mem_wren    = 1'b0;
                O_cpu_rd_data = rd_hold;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/sprite_dma.md
Name: sprite_dma

Overview:
- Controller that owns the CPU-side port of the shared dual-port memory and arbitrates it between the CPU core and a page-copy DMA engine.
- When the CPU writes a page number to the trigger address, the block:
  - halts the CPU through its ready input;
  - copies P_len bytes from {page, 8'h00} to P_dst_base (sprite attribute region);
  - releases the CPU.
- Sits between the core and port 1 of dpmem. The video port of dpmem is untouched.

Parameters:
- P_addr_bits, 16, memory address width
- P_data_bits, 8, memory data width
- P_trig_addr, 16'h4014, CPU write address that starts a transfer
- P_dst_base, 16'h4800, destination start address of the copy
- P_len, 256, bytes per transfer, legal range 1..256

Ports:
- I_clock  in  1  system clock, single clock domain
- I_reset  in  1  asynchronous, active-high reset
- I_cpu_addr  in  P_addr_bits  CPU bus address
- I_cpu_wr_data  in  P_data_bits  CPU write data
- I_cpu_rdwr  in  1  1 = read, 0 = write
- I_cpu_phy2  in  1  CPU cycle strobe; a bus cycle completes on the I_clock edge where it is 1
- O_cpu_rd_data  out  P_data_bits  read data returned to the CPU
- O_cpu_ready  out  1  CPU ready/RDY; 0 halts the CPU
- O_mem_addr  out  P_addr_bits  memory port address
- O_mem_wr_data  out  P_data_bits  memory port write data
- O_mem_wren  out  1  memory port write enable
- I_mem_rd_data  in  P_data_bits  memory read data, 1-clock synchronous latency
- O_dma_busy  out  1  1 while any state other than IDLE

Behaviour:
- Clock and reset:
  - One clock (I_clock).
  - Reset is asynchronous and active-high on I_reset.
  - Reset forces state IDLE, page = 0, count = 0, src/dst offset = 0.
  - Reset values: O_cpu_ready = 1, O_dma_busy = 0, O_mem_wren = 0.
- States: IDLE, HALT, READ, WRITE, DONE.
- Pass-through (IDLE and HALT):
  - O_mem_addr = I_cpu_addr, O_mem_wr_data = I_cpu_wr_data.
  - O_mem_wren = I_cpu_phy2 & ~I_cpu_rdwr.
  - O_cpu_rd_data = I_mem_rd_data.
- Trigger:
  - Condition: in IDLE, at an edge with I_cpu_phy2 = 1, I_cpu_rdwr = 0 and I_cpu_addr = P_trig_addr.
  - Actions: page <= I_cpu_wr_data, count <= 0, state -> HALT.
  - The trigger write itself is suppressed: O_mem_wren = 0 for that cycle, combinationally decoded.
- O_cpu_ready = 0 in HALT, READ, WRITE and DONE. It is combinational from state.
- HALT:
  - The CPU may still complete writes; they pass through to memory.
  - HALT -> READ at the first edge with I_cpu_phy2 = 1 and I_cpu_rdwr = 1, i.e. the CPU is parked on a read.
- READ:
  - O_mem_addr = {page, count[7:0]}, O_mem_wren = 0.
  - Next state WRITE.
- WRITE:
  - O_mem_addr = P_dst_base + count, O_mem_wr_data = I_mem_rd_data, O_mem_wren = 1.
  - If count == P_len-1 -> DONE, else count <= count+1 -> READ.
- DONE: one clock, DMA owns the port with wren = 0; then -> IDLE.
- Throughput: 2 clocks per byte. Busy time = HALT wait + 2*P_len + 1 clocks.
- O_cpu_rd_data during DMA states: holds the last pass-through value (registered on HALT exit), so the stalled read sees stable data.
- Arithmetic:
  - count is 9 bits internally so P_len = 256 terminates.
  - Source low byte is count[7:0].
  - Destination add is modulo 2^P_addr_bits (wraps at 16'hFFFF).
- CPU activity during READ/WRITE/DONE is ignored: a trigger there cannot start a nested transfer.
- Reset mid-transfer aborts immediately. Bytes already written remain, and the CPU is released (ready = 1).

Decomposition:
- Shared package (e.g. fpgame_pkg):
  - state enum type dma_state_t;
  - constants for the trigger address and sprite base, reused by address decode elsewhere.
- Sub-module: none needed. An optional mem_mux (pass-through vs DMA port select) is acceptable as a small combinational helper.

Test Plan:
- Reset idle:
  - Stimulus: hold I_reset, then release.
  - Response: O_cpu_ready = 1, O_dma_busy = 0, O_mem_wren = 0.
  - Then: CPU write 8'hAA to 16'h0010 -> O_mem_wren pulse at 16'h0010 with data 8'hAA.
- Full transfer:
  - Stimulus: preload 16'h0200..16'h02FF with i^8'h5A; CPU writes 8'h02 to 16'h4014, then a CPU read cycle.
  - Response: O_cpu_ready drops the cycle after the trigger; exactly 256 wren pulses at 16'h4800..16'h48FF with data i^8'h5A; O_cpu_ready returns 1 after DONE.
  - Trigger write never reaches memory.
- HALT with pending writes:
  - Stimulus: after the trigger, two CPU write cycles (16'h0300 <= 8'h11, 16'h0301 <= 8'h22), then a read.
  - Response: both writes land in memory; the DMA starts only after the read edge.
- Reset mid-operation:
  - Stimulus: assert I_reset during byte 100.
  - Response: immediate IDLE, ready = 1; 16'h4800..16'h4863 are written, 16'h4864 is unchanged.
- Parameter edge:
  - Stimulus: P_len = 1, P_dst_base = 16'hFFFF.
  - Response: a single write to 16'hFFFF; busy for HALT + 3 clocks.
- Spurious trigger:
  - Stimulus: CPU read of 16'h4014, or a write to 16'h4015.
  - Response: no transfer, ready stays 1.
